// File: rtl/shortcut_preset_adder_if.sv
// shortcut_preset_adder_if: keypad, time-in/out digits and status of the preset adder
interface shortcut_preset_adder_if;
  logic       en;
  logic [9:0] keypad;
  logic       sharp;
  logic       star;
  logic [3:0] hour_ten_in, hour_one_in, min_ten_in, min_one_in, sec_ten_in, sec_one_in;
  logic [3:0] hour_ten_out, hour_one_out, min_ten_out, min_one_out, sec_ten_out, sec_one_out;
  logic       completeSetting;
  logic       busy;
  logic [3:0] press_count;
  modport master (
    output en, keypad, sharp, star,
    output hour_ten_in, hour_one_in, min_ten_in, min_one_in, sec_ten_in, sec_one_in,
    input  hour_ten_out, hour_one_out, min_ten_out, min_one_out, sec_ten_out, sec_one_out,
    input  completeSetting, busy, press_count
  );
  modport slave (
    input  en, keypad, sharp, star,
    input  hour_ten_in, hour_one_in, min_ten_in, min_one_in, sec_ten_in, sec_one_in,
    output hour_ten_out, hour_one_out, min_ten_out, min_one_out, sec_ten_out, sec_one_out,
    output completeSetting, busy, press_count
  );
endinterface

// File: rtl/shortcut_preset_adder.sv
// shortcut_preset_adder: keypad presets accumulate into a BCD offset; '#' commits time_in + offset
// through one shared digit-serial adder (sec_one, sec_ten, min_one, min_ten, hours).
module shortcut_preset_adder #(
  parameter int             NUM_PRESETS = 3,
  parameter logic [239:0]   PRESETS     = {{7{24'h0}}, 24'h000100, 24'h000030, 24'h000005},
  parameter int             MAX_PRESSES = 9
) (
  input logic                    clk,
  input logic                    rst,
  shortcut_preset_adder_if.slave bus
);
  typedef enum logic [2:0] {IDLE, COLLECT, ACC, COMMIT, DONE} state_t;
  localparam logic [9:0] KEY_MASK = 10'((11'd1 << NUM_PRESETS) - 11'd1);
  localparam logic [3:0] MAX_CNT  = 4'(MAX_PRESSES);
  state_t      state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic        carry_q, carry_d;
  logic [23:0] off_q, off_d;
  logic [23:0] snap_q, snap_d;
  logic [23:0] out_q, out_d;
  logic [3:0]  count_q, count_d;
  logic [3:0]  key_q, key_d;
  logic        pend_q, pend_d;
  logic [9:0]  kp_q, kp_d;
  logic        sharp_q, sharp_d;
  logic        star_q, star_d;
  logic [23:0] time_in;
  logic        key_ev, sharp_ev, star_ev;
  logic [3:0]  key_idx;
  logic [23:0] op_a, op_b, sum_word;
  logic [4:0]  sh, base, dsum;
  logic [3:0]  a_nib, b_nib, dig;
  logic        wrap, last;
  logic [8:0]  hsum, hmod;
  assign time_in = {bus.hour_ten_in, bus.hour_one_in, bus.min_ten_in,
                    bus.min_one_in, bus.sec_ten_in, bus.sec_one_in};
  always_comb begin
    key_idx = '0;
    for (int i = 0; i < 10; i++) key_idx = bus.keypad[i] ? 4'(i) : key_idx;
    key_ev   = (kp_q == '0) && $onehot(bus.keypad) && ((bus.keypad & ~KEY_MASK) == '0);
    sharp_ev = bus.sharp & ~sharp_q;
    star_ev  = bus.star & ~star_q;
  end
  // ACC adds the selected preset into the offset; COMMIT adds the offset into the snapshot.
  always_comb begin
    op_a  = (state_q == COMMIT) ? snap_q : off_q;
    op_b  = (state_q == COMMIT) ? off_q : 24'(PRESETS >> ({4'b0, key_q} * 8'd24));
    last  = step_q == 3'd4;
    sh    = {1'b0, step_q[1:0], 2'b00};
    a_nib = 4'(op_a >> sh);
    b_nib = 4'(op_b >> sh);
    base  = step_q[0] ? 5'd6 : 5'd10;
    dsum  = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0, carry_q};
    wrap  = dsum >= base;
    dig   = wrap ? 4'(dsum - base) : dsum[3:0];
    hsum  = 9'(op_a[23:20]) * 9'd10 + 9'(op_a[19:16]) +
            9'(op_b[23:20]) * 9'd10 + 9'(op_b[19:16]) + 9'(carry_q);
    hmod  = hsum % 9'd24;
    sum_word = last ? {4'(hmod / 9'd10), 4'(hmod % 9'd10), op_a[15:0]}
                    : (op_a & ~(24'hF << sh)) | (24'(dig) << sh);
  end
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    carry_d = carry_q;
    off_d   = off_q;
    snap_d  = snap_q;
    out_d   = out_q;
    count_d = count_q;
    key_d   = key_q;
    pend_d  = pend_q;
    kp_d    = bus.keypad;
    sharp_d = bus.sharp;
    star_d  = bus.star;
    case (state_q)
      IDLE: begin
        off_d   = '0;
        count_d = '0;
        pend_d  = 1'b0;
        state_d = bus.en ? COLLECT : IDLE;
      end
      COLLECT:
        if (!bus.en) state_d = IDLE;
        else if (key_ev && count_q < MAX_CNT) begin
          state_d = ACC;
          count_d = count_q + 4'd1;
          key_d   = key_idx;
          step_d  = '0;
          carry_d = 1'b0;
          pend_d  = sharp_ev;
        end else if (sharp_ev) begin
          state_d = COMMIT;
          snap_d  = time_in;
          step_d  = '0;
          carry_d = 1'b0;
        end else if (star_ev) begin
          off_d   = '0;
          count_d = '0;
        end
      ACC:
        if (!bus.en) state_d = IDLE;
        else begin
          off_d   = sum_word;
          carry_d = wrap & ~last;
          step_d  = last ? 3'd0 : step_q + 3'd1;
          pend_d  = (pend_q | sharp_ev) & ~last;
          if (last) begin
            state_d = (pend_q | sharp_ev) ? COMMIT : COLLECT;
            snap_d  = time_in;
          end
        end
      COMMIT:
        if (!bus.en) state_d = IDLE;
        else begin
          snap_d  = sum_word;
          carry_d = wrap & ~last;
          step_d  = last ? 3'd0 : step_q + 3'd1;
          if (last) begin
            out_d   = sum_word;
            state_d = DONE;
          end
        end
      DONE: begin
        off_d   = '0;
        count_d = '0;
        state_d = COLLECT;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= '0;
      carry_q <= 1'b0;
      off_q   <= '0;
      snap_q  <= '0;
      out_q   <= '0;
      count_q <= '0;
      key_q   <= '0;
      pend_q  <= 1'b0;
      kp_q    <= '0;
      sharp_q <= 1'b0;
      star_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      carry_q <= carry_d;
      off_q   <= off_d;
      snap_q  <= snap_d;
      out_q   <= out_d;
      count_q <= count_d;
      key_q   <= key_d;
      pend_q  <= pend_d;
      kp_q    <= kp_d;
      sharp_q <= sharp_d;
      star_q  <= star_d;
    end
  end
  assign {bus.hour_ten_out, bus.hour_one_out, bus.min_ten_out,
          bus.min_one_out, bus.sec_ten_out, bus.sec_one_out} = out_q;
  assign bus.completeSetting = state_q == DONE;
  assign bus.busy            = (state_q == ACC) || (state_q == COMMIT);
  assign bus.press_count     = count_q;
endmodule

// File: doc/shortcut_preset_adder.md
# shortcut_preset_adder

Parametrised successor to the fixed three-button shortcut setter in the nap-timer setting path. The block turns keypad presses into a configurable preset table of BCD durations. Repeated presses accumulate into a pending offset; `#` commits `time_in + offset` with 60/60/24 wrap. Arithmetic is a shared digit-serial BCD adder, and `completeSetting` is pulsed when the adjusted HH:MM:SS is ready for the alarm/countdown stage.

## Interface
Parameters:
- NUM_PRESETS, 3, number of active preset keys (1..10); keys k >= NUM_PRESETS are ignored.
- PRESETS, {7{24'h0}, 24'h000100, 24'h000030, 24'h000005}, packed 240-bit BCD HHMMSS table; key k uses [24k+23:24k]. Defaults: key0 = 5 s, key1 = 30 s, key2 = 1 min.
- MAX_PRESSES, 9, number of accepted presses per setting session; further presses are ignored.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  setting mode enable.
- keypad  in  10  one-hot level keys 0..9.
- sharp  in  1  commit key (level).
- star  in  1  cancel key (level).
- hour_ten_in..sec_one_in  in  4 each  current time, BCD.
- hour_ten_out..sec_one_out  out  4 each  registered adjusted time, BCD.
- completeSetting  out  1  one-cycle done pulse.
- busy  out  1  high in ACC and COMMIT.
- press_count  out  4  presses accepted this session.

## Operation
- Events are registered rising edges on the inputs.
  - A key press is valid only if `keypad` goes from all-zero to exactly one bit set with index < NUM_PRESETS. Multi-bit or out-of-range values are ignored.
  - `sharp` and `star` events are 0->1 transitions.
- FSM states:
  - IDLE: `en` = 0. Offset and count are cleared; outputs hold.
  - COLLECT: waits for events. If `en` drops, go to IDLE.
  - ACC: `offset += PRESETS[k]`.
  - COMMIT: `result = snapshot + offset`.
  - DONE: one cycle.
- Transitions:
  - IDLE -> COLLECT when `en` = 1.
  - COLLECT + key (count < MAX_PRESSES) -> ACC. Count increments on entry.
  - ACC -> COLLECT after 5 cycles. If a `sharp` was latched during ACC, go directly to COMMIT instead.
  - COLLECT + sharp -> COMMIT. The six `*_in` digits are snapshotted in the same cycle.
  - COMMIT -> DONE after 5 cycles. DONE -> COLLECT, with offset and count cleared.
  - `star` in COLLECT clears offset and count. No pulse.
- Events are ignored in ACC and COMMIT, except that `sharp` is latched during ACC.
- Adder behaviour:
  - One step per cycle, in order: sec_one (mod 10), sec_ten (mod 6), min_one (mod 10), min_ten (mod 6), hours (two digits combined, binary 0..23 plus offset plus carry, mod 24, re-split to BCD).
  - The carry flop is cleared at the start of each operation. The hour step discards carry-out.
  - The offset itself wraps mod 24 h.
- Outputs update only in the DONE transition (all six digits at once); ACC never changes them.
- A `sharp` with zero presses commits `time_in` unchanged and still pulses.
- `en` falling during ACC or COMMIT aborts to IDLE. Outputs keep their old values and there is no pulse.
- Illegal BCD inputs (>9, or ten digits >5) are passed through the same arithmetic with no checking.

## Timing
- Reset values: all output digits 0, `completeSetting` 0, `busy` 0, `press_count` 0. FSM goes to IDLE, offset 0, edge registers 0.
- `rst` has priority over every event, including mid-ACC or mid-COMMIT.
- Key edge sampled at cycle t: `busy` is high t+1..t+5, and COLLECT is re-entered at t+6.
- Sharp sampled at cycle s (in COLLECT): `busy` is high s+1..s+5. Outputs and `completeSetting` are valid at s+6, with `completeSetting` high for exactly one cycle.
- Sharp latched during ACC: COMMIT starts the cycle after ACC ends. The snapshot is taken at that cycle.
- Minimum key-to-key spacing is 6 cycles. Faster edges are dropped.

## Test plan
- Default table, `time_in` 00:00:00, keys 1,1,0 then `#` -> outputs 00:01:05, `press_count` = 3, pulse 6 cycles after `#`.
- `time_in` 23:59:58, key 0 then `#` -> 00:00:03. This checks every carry and the 24 h wrap.
- Ten presses of key 2 with MAX_PRESSES = 9 -> `press_count` = 9, result `time_in` + 00:09:00. Key 5, and key 0 pressed with key 1 held, are both ignored.
- Key 2, then `*`, then `#` at 12:34:56 -> 12:34:56. Pulse asserted.
- `#` pressed 2 cycles after a key edge -> commit follows ACC and the result includes that key. `en` dropped mid-COMMIT -> no pulse, old outputs kept.
- `rst` asserted mid-COMMIT -> next cycle all outputs 0, `busy` 0. A key pressed afterwards with `en` = 1 is accepted normally.
